// File: rtl/bounce_scheduler.sv
// Per-frame wall-bounce sequencer for a bank of ball movers: scans one ball per clock, then pulses ball_tick.
// Optional feature: define BOUNCE_COUNT_EN to enable the saturating bounce_cnt counter (tied to zero otherwise).
module bounce_scheduler #(
    parameter int unsigned NUM_BALLS = 4,
    parameter int unsigned X_MAX     = 159,
    parameter int unsigned Y_MAX     = 119
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_tick,
    input  logic                   start,
    input  logic                   stop,
    input  logic [8*NUM_BALLS-1:0] x_bus,
    input  logic [8*NUM_BALLS-1:0] y_bus,
    output logic [NUM_BALLS-1:0]   dir_x_bus,
    output logic [NUM_BALLS-1:0]   dir_y_bus,
    output logic                   run,
    output logic                   ball_tick,
    output logic                   busy,
    output logic                   overrun,
    output logic [15:0]            bounce_cnt
);

    localparam int unsigned IW = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
    localparam logic [8:0] XM  = 9'(X_MAX);
    localparam logic [8:0] XM8 = 9'(X_MAX + 8);
    localparam logic [8:0] YM  = 9'(Y_MAX);
    localparam logic [8:0] YM8 = 9'(Y_MAX + 8);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        TICK
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [NUM_BALLS-1:0] dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [NUM_BALLS-1:0] dir_x_rst, dir_y_rst;
    logic                 run_q, run_d;
    logic                 overrun_q, overrun_d;
    logic [7:0]           cur_x, cur_y;
    logic                 cur_dx, cur_dy;
    logic                 flip_x, flip_y;

    // Reset direction pattern: ball i starts with dir_x=i[0], dir_y=i[1].
    always_comb begin
        dir_x_rst = '0;
        dir_y_rst = '0;
        for (int unsigned i = 0; i < NUM_BALLS; i++) begin
            dir_x_rst[i] = ((i % 2) == 1);
            dir_y_rst[i] = (((i / 2) % 2) == 1);
        end
    end

    always_comb begin
        cur_x  = '0;
        cur_y  = '0;
        cur_dx = 1'b0;
        cur_dy = 1'b0;
        for (int unsigned i = 0; i < NUM_BALLS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_x  = x_bus[8*i +: 8];
                cur_y  = y_bus[8*i +: 8];
                cur_dx = dir_x_q[i];
                cur_dy = dir_y_q[i];
            end
        end
    end

    // Positions above MAX are wrapped underflows, so they bounce back toward the playfield.
    always_comb begin
        flip_x = 1'b0;
        flip_y = 1'b0;
        if (state_q == SCAN) begin
            if (cur_dx)
                flip_x = ({1'b0, cur_x} >= XM) && ({1'b0, cur_x} <= XM8);
            else
                flip_x = (cur_x == 8'd0) || ({1'b0, cur_x} > XM);
            if (cur_dy)
                flip_y = ({1'b0, cur_y} >= YM) && ({1'b0, cur_y} <= YM8);
            else
                flip_y = (cur_y == 8'd0) || ({1'b0, cur_y} > YM);
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        overrun_d = overrun_q;
        run_d     = run_q;

        if (stop)
            run_d = 1'b0;
        else if (start)
            run_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                for (int unsigned i = 0; i < NUM_BALLS; i++) begin
                    if (idx_q == IW'(i)) begin
                        dir_x_d[i] = dir_x_q[i] ^ flip_x;
                        dir_y_d[i] = dir_y_q[i] ^ flip_y;
                    end
                end
                if (idx_q == IW'(NUM_BALLS - 1)) begin
                    state_d = TICK;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            TICK:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (frame_tick && (state_q != IDLE))
            overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            dir_x_q   <= dir_x_rst;
            dir_y_q   <= dir_y_rst;
            run_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            run_q     <= run_d;
            overrun_q <= overrun_d;
        end
    end

    assign dir_x_bus = dir_x_q;
    assign dir_y_bus = dir_y_q;
    assign run       = run_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);
    assign ball_tick = (state_q == TICK);

`ifdef BOUNCE_COUNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic [16:0] cnt_sum;

    always_comb begin
        cnt_sum = {1'b0, cnt_q} + 17'(flip_x) + 17'(flip_y);
        cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign bounce_cnt = cnt_q;
`else
    assign bounce_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_bounce_scheduler.sv
// Self-checking bench for bounce_scheduler: directed frames plus randomized frames against a frame-level model.
module tb_bounce_scheduler;

    localparam int N     = 4;
    localparam int X_MAX = 159;
    localparam int Y_MAX = 119;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           frame_tick = 1'b0;
    logic           start = 1'b0;
    logic           stop = 1'b0;
    logic [8*N-1:0] x_bus = '0;
    logic [8*N-1:0] y_bus = '0;
    logic [N-1:0]   dir_x_bus, dir_y_bus;
    logic           run, ball_tick, busy, overrun;
    logic [15:0]    bounce_cnt;

    bounce_scheduler #(.NUM_BALLS(N), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick),
        .start     (start),
        .stop      (stop),
        .x_bus     (x_bus),
        .y_bus     (y_bus),
        .dir_x_bus (dir_x_bus),
        .dir_y_bus (dir_y_bus),
        .run       (run),
        .ball_tick (ball_tick),
        .busy      (busy),
        .overrun   (overrun),
        .bounce_cnt(bounce_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]   px [N];
    logic [7:0]   py [N];
    logic [N-1:0] exp_dx, exp_dy;
    bit           exp_run, exp_ovr, in_frame;
    int           exp_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        if (stop) exp_run = 1'b0;
        else if (start) exp_run = 1'b1;
        if (frame_tick && in_frame) exp_ovr = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        start = 1'b0;
        stop = 1'b0;
    endtask

    task automatic model_reset();
        exp_dx = 4'b1010;
        exp_dy = 4'b1100;
        exp_run = 1'b0;
        exp_ovr = 1'b0;
        exp_cnt = 0;
        in_frame = 1'b0;
    endtask

    task automatic check_cnt(input string tag);
`ifdef BOUNCE_COUNT_EN
        check_eq(tag, 32'(bounce_cnt), 32'(exp_cnt));
`else
        check_eq(tag, 32'(bounce_cnt), 32'h0);
`endif
    endtask

    task automatic apply_pos();
        for (int i = 0; i < N; i++) begin
            x_bus[8*i +: 8] = px[i];
            y_bus[8*i +: 8] = py[i];
        end
    endtask

    function automatic bit wall(input int p, input bit dir, input int maxv);
        if (dir) return (p >= maxv) && (p <= maxv + 8);
        return (p == 0) || (p > maxv);
    endfunction

    function automatic logic [7:0] pick(input int maxv);
        case ($urandom_range(0, 7))
            0:       return 8'd0;
            1:       return 8'(maxv);
            2:       return 8'(maxv + 8);
            3:       return 8'(maxv + 9);
            4:       return 8'd255;
            5:       return 8'(maxv - 1);
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // One accepted frame starting in the current cycle; dup_k>0 re-pulses frame_tick in cycle T+dup_k.
    task automatic run_frame(input int dup_k, input bit rand_ctl);
        logic [N-1:0] ndx, ndy;
        int flips;
        apply_pos();
        frame_tick = 1'b1;
        check_eq("accept_busy", 32'(busy), 32'h0);
        check_eq("accept_tick", 32'(ball_tick), 32'h0);
        ndx = exp_dx;
        ndy = exp_dy;
        flips = 0;
        for (int i = 0; i < N; i++) begin
            if (wall(int'(px[i]), exp_dx[i], X_MAX)) begin ndx[i] = ~exp_dx[i]; flips++; end
            if (wall(int'(py[i]), exp_dy[i], Y_MAX)) begin ndy[i] = ~exp_dy[i]; flips++; end
        end
        for (int k = 1; k <= N + 1; k++) begin
            step();
            in_frame = 1'b1;
            if (k == dup_k) frame_tick = 1'b1;
            if (rand_ctl) begin
                start = ($urandom_range(0, 3) == 0);
                stop  = ($urandom_range(0, 3) == 0);
            end
            check_eq("frame_busy", 32'(busy), 32'h1);
            check_eq("frame_tick_out", 32'(ball_tick), 32'(k == N + 1));
            check_eq("frame_run", 32'(run), 32'(exp_run));
            check_eq("frame_ovr", 32'(overrun), 32'(exp_ovr));
        end
        exp_dx = ndx;
        exp_dy = ndy;
        exp_cnt = (exp_cnt + flips > 65535) ? 65535 : exp_cnt + flips;
        check_eq("dir_x", 32'(dir_x_bus), 32'(exp_dx));
        check_eq("dir_y", 32'(dir_y_bus), 32'(exp_dy));
        check_cnt("bounce_cnt");
        step();
        in_frame = 1'b0;
        check_eq("post_busy", 32'(busy), 32'h0);
        check_eq("post_tick", 32'(ball_tick), 32'h0);
        check_eq("post_ovr", 32'(overrun), 32'(exp_ovr));
    endtask

    task automatic center_all();
        for (int i = 0; i < N; i++) begin
            px[i] = 8'd80;
            py[i] = 8'd60;
        end
    endtask

    initial begin
        model_reset();
        center_all();
        apply_pos();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        model_reset();
        step();
        check_eq("rst_dir_x", 32'(dir_x_bus), 32'hA);
        check_eq("rst_dir_y", 32'(dir_y_bus), 32'hC);
        check_eq("rst_run", 32'(run), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_tick", 32'(ball_tick), 32'h0);
        check_eq("rst_ovr", 32'(overrun), 32'h0);
        check_cnt("rst_cnt");

        // No walls anywhere: directions unchanged.
        run_frame(0, 1'b0);

        // Ball 2 hits the bottom to get dir_y=0, then a wrapped y plus ball 1 at the right wall.
        py[2] = 8'd119;
        run_frame(0, 1'b0);
        py[2] = 8'd255;
        px[1] = 8'd159;
        run_frame(0, 1'b0);

        // Corner at (0,0) flips both axes of ball 0.
        center_all();
        px[0] = 8'd0;
        py[0] = 8'd0;
        run_frame(0, 1'b0);

        // Dropped frame_tick while busy, then back-to-back accepted frame.
        center_all();
        run_frame(3, 1'b0);
        check_eq("ovr_sticky", 32'(overrun), 32'h1);
        run_frame(0, 1'b0);

        // start/stop priority.
        start = 1'b1;
        step();
        check_eq("start_run", 32'(run), 32'(exp_run));
        start = 1'b1;
        stop = 1'b1;
        step();
        check_eq("both_run", 32'(run), 32'h0);
        start = 1'b1;
        step();
        check_eq("restart_run", 32'(run), 32'h1);

        // Reset in the middle of a scan.
        px[0] = 8'd0;
        py[1] = 8'd0;
        apply_pos();
        frame_tick = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        check_eq("mid_rst_busy", 32'(busy), 32'h0);
        check_eq("mid_rst_tick", 32'(ball_tick), 32'h0);
        check_eq("mid_rst_dx", 32'(dir_x_bus), 32'hA);
        check_eq("mid_rst_dy", 32'(dir_y_bus), 32'hC);
        check_eq("mid_rst_run", 32'(run), 32'h0);
        check_eq("mid_rst_ovr", 32'(overrun), 32'h0);
        check_cnt("mid_rst_cnt");
        for (int k = 0; k < N + 2; k++) begin
            step();
            check_eq("mid_rst_idle_tick", 32'(ball_tick), 32'h0);
            check_eq("mid_rst_idle_busy", 32'(busy), 32'h0);
        end

        // Randomized frames with random positions, run control and stray frame pulses.
        for (int f = 0; f < 80; f++) begin
            for (int i = 0; i < N; i++) begin
                px[i] = pick(X_MAX);
                py[i] = pick(Y_MAX);
            end
            run_frame(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N + 1)) : 0, 1'b1);
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                start = ($urandom_range(0, 2) == 0);
                stop  = ($urandom_range(0, 2) == 0);
                step();
                check_eq("gap_run", 32'(run), 32'(exp_run));
                check_eq("gap_busy", 32'(busy), 32'h0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
